// File: rtl/digital_clock_hms.sv
// BCD hours/minutes/seconds clock advanced by a synchronized 1 Hz input.
// Supports validated time loading and a sticky, acknowledgeable minute alarm.
module digital_clock_hms #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nclk_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       alarm,
  output logic       load_err
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [7:0]             hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic                   sec_pulse_q, sec_pulse_d;
  logic                   alarm_q, alarm_d;
  logic                   load_err_q, load_err_d;
  logic                   tick, load_ok, advance;

  // Wraps to zero at max, otherwise a BCD +1 with low-digit carry.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return '0;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], nclk_in};
    prev_d      = sync_q[SYNC_STAGES-1];
    tick        = sync_q[SYNC_STAGES-1] & ~prev_q;
    load_ok     = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    sec_pulse_d = 1'b0;
    load_err_d  = 1'b0;
    advance     = 1'b0;

    // Any load, valid or not, swallows a coincident tick.
    if (load) begin
      if (load_ok) begin
        hh_d = load_hh;
        mm_d = load_mm;
        ss_d = load_ss;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick && run) begin
      advance     = 1'b1;
      sec_pulse_d = 1'b1;
      ss_d        = bcd_step(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_step(mm_q, 8'h59);
        if (mm_q == 8'h59)
          hh_d = bcd_step(hh_q, 8'h23);
      end
    end

    // Set wins over ack/disable when both land on the same edge.
    alarm_d = alarm_q;
    if (alarm_ack || !alarm_en)
      alarm_d = 1'b0;
    if (advance && alarm_en && hh_d == alarm_hh && mm_d == alarm_mm && ss_d == 8'h00)
      alarm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      sec_pulse_q <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      sec_pulse_q <= sec_pulse_d;
      alarm_q     <= alarm_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_pulse = sec_pulse_q;
  assign alarm     = alarm_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_digital_clock_hms.sv
// Bench for digital_clock_hms: directed scenarios plus random traffic against a
// seconds-of-day reference model with a fixed tick latency.
module tb_digital_clock_hms;

  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nclk_in = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_hh = '0, load_mm = '0, load_ss = '0;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hh = '0, alarm_mm = '0;
  logic       alarm_ack = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       sec_pulse, alarm, load_err;

  always #5 clk = ~clk;

  digital_clock_hms #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .nclk_in(nclk_in), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_ack(alarm_ack), .hh(hh), .mm(mm), .ss(ss),
    .sec_pulse(sec_pulse), .alarm(alarm), .load_err(load_err)
  );

  int tests = 0;
  int fails = 0;
  int m_secs = 0;
  bit m_pulse = 0, m_alarm = 0, m_err = 0;
  int cd = 0;        // clk edges left until a seen nclk_in rise is counted
  int pulses = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] b, input logic [7:0] max);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b <= max);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("hh", {24'd0, hh}, {24'd0, to_bcd(m_secs / 3600)});
    check("mm", {24'd0, mm}, {24'd0, to_bcd((m_secs / 60) % 60)});
    check("ss", {24'd0, ss}, {24'd0, to_bcd(m_secs % 60)});
    check("sec_pulse", {31'd0, sec_pulse}, {31'd0, m_pulse});
    check("alarm", {31'd0, alarm}, {31'd0, m_alarm});
    check("load_err", {31'd0, load_err}, {31'd0, m_err});
  endtask

  task automatic model_edge();
    bit t, nal;
    int tgt;
    if (!rst_n) return;
    t = 0;
    if (cd > 0) begin
      cd--;
      t = (cd == 0);
    end
    m_pulse = 0;
    m_err   = 0;
    nal = m_alarm;
    if (alarm_ack || !alarm_en) nal = 0;
    if (load) begin
      if (field_ok(load_hh, 8'h23) && field_ok(load_mm, 8'h59) && field_ok(load_ss, 8'h59))
        m_secs = from_bcd(load_hh) * 3600 + from_bcd(load_mm) * 60 + from_bcd(load_ss);
      else
        m_err = 1;
    end else if (t && run) begin
      m_secs  = (m_secs + 1) % 86400;
      m_pulse = 1;
      tgt = from_bcd(alarm_hh) * 3600 + from_bcd(alarm_mm) * 60;
      if (alarm_en && field_ok(alarm_hh, 8'h23) && field_ok(alarm_mm, 8'h59) && m_secs == tgt)
        nal = 1;
    end
    m_alarm = nal;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (sec_pulse) pulses++;
  endtask

  task automatic set_nclk(input bit v);
    if (v && !nclk_in && rst_n) cd = SYNC + 1;
    nclk_in = v;
  endtask

  task automatic tick_wait();
    set_nclk(1);
    repeat (5) step();
    set_nclk(0);
    repeat (5) step();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hh = h; load_mm = m; load_ss = s;
    load = 1;
    step();
    load = 0;
  endtask

  task automatic do_reset(input bit nclk_at_release);
    #2 rst_n = 0;
    #1;
    check("rst_hh", {24'd0, hh}, 32'd0);
    check("rst_mm", {24'd0, mm}, 32'd0);
    check("rst_ss", {24'd0, ss}, 32'd0);
    check("rst_flags", {29'd0, sec_pulse, alarm, load_err}, 32'd0);
    m_secs = 0; m_pulse = 0; m_alarm = 0; m_err = 0; cd = 0;
    repeat (3) step();
    nclk_in = nclk_at_release;
    rst_n = 1;
    if (nclk_in) cd = SYNC + 1;
  endtask

  int p0, nclk_cnt, t, n;

  initial begin
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    step();

    // Basic count with exact latency checked cycle by cycle.
    run = 1;
    pulses = 0;
    repeat (3) tick_wait();
    check("basic_ss", {24'd0, ss}, 32'h03);
    check("basic_pulses", pulses, 3);

    // Full-day wrap.
    do_load(8'h23, 8'h59, 8'h59);
    p0 = pulses;
    tick_wait();
    check("wrap_time", {8'd0, hh, mm, ss}, 32'h000000);
    check("wrap_pulses", pulses - p0, 1);

    // Invalid loads.
    do_load(8'h10, 8'h60, 8'h00);
    check("bad_mm_err", {31'd0, load_err}, 32'd1);
    step();
    check("bad_mm_clr", {31'd0, load_err}, 32'd0);
    do_load(8'h1A, 8'h00, 8'h00);
    check("bad_hh_err", {31'd0, load_err}, 32'd1);
    check("bad_hh_time", {8'd0, hh, mm, ss}, 32'h000000);
    step();

    // Load colliding with the tick edge.
    p0 = pulses;
    set_nclk(1);
    step();
    step();
    do_load(8'h12, 8'h00, 8'h00);
    check("coll_time", {8'd0, hh, mm, ss}, 32'h120000);
    check("coll_pulse", {31'd0, sec_pulse}, 32'd0);
    repeat (3) step();
    set_nclk(0);
    repeat (5) step();
    check("coll_pulses", pulses - p0, 0);
    tick_wait();
    check("coll_next", {8'd0, hh, mm, ss}, 32'h120001);

    // Alarm set, ack, and no-set on load.
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_en = 1;
    do_load(8'h07, 8'h29, 8'h59);
    tick_wait();
    check("alarm_set", {31'd0, alarm}, 32'd1);
    check("alarm_time", {8'd0, hh, mm, ss}, 32'h073000);
    alarm_ack = 1;
    step();
    alarm_ack = 0;
    check("alarm_ack", {31'd0, alarm}, 32'd0);
    do_load(8'h07, 8'h30, 8'h00);
    step();
    check("alarm_load", {31'd0, alarm}, 32'd0);

    // Run gating, then reset mid-operation with nclk_in high at release.
    run = 0;
    p0 = pulses;
    repeat (2) tick_wait();
    check("run0_time", {8'd0, hh, mm, ss}, 32'h073000);
    check("run0_pulses", pulses - p0, 0);
    run = 1;
    set_nclk(1);
    step();
    do_reset(1);
    repeat (6) step();
    check("rst_release_ss", {24'd0, ss}, 32'h01);
    set_nclk(0);
    repeat (5) step();

    // Random traffic.
    nclk_cnt = 4;
    for (int c = 0; c < 3000; c++) begin
      if (nclk_cnt == 0) begin
        set_nclk(!nclk_in);
        nclk_cnt = $urandom_range(4, 12);
      end else begin
        nclk_cnt--;
      end
      run = ($urandom_range(0, 9) != 0);
      alarm_ack = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) alarm_en = !alarm_en;
      load = 0;
      if ($urandom_range(0, 39) == 0) begin
        load = 1;
        if ($urandom_range(0, 3) == 0) begin
          load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
        end else begin
          t = $urandom_range(0, 1439) * 60 + $urandom_range(55, 59);
          load_hh = to_bcd(t / 3600);
          load_mm = to_bcd((t / 60) % 60);
          load_ss = to_bcd(t % 60);
          if ($urandom_range(0, 1) == 1) begin
            n = (t / 60 + 1) % 1440;
            alarm_hh = to_bcd(n / 60);
            alarm_mm = to_bcd(n % 60);
          end
        end
      end
      step();
    end
    load = 0;
    alarm_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
